rst_seq_ctrl: RTL and testbench

- Reset sequencer for testbench and SoC-level reset trees.
- After the global reset deasserts, releases NumDomains reset outputs one at a time in index order, with a programmable gap before each release.
- Accepts software soft-reset requests through a req/ack handshake. A request pulses a selected subset of domains, then re-releases that subset in order.
- Sits between the global clock/reset source and the per-subsystem reset inputs.

---
 rtl/rst_seq_pkg.sv | 42 ++++
 rtl/rst_seq_cnt.sv | 27 ++
 rtl/rst_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and mask-scan helpers for the reset sequencer.
package rst_seq_pkg;

    localparam int MaxDomains = 32;
    localparam int IdxW       = 5;

    typedef enum logic [1:0] {
        SEQ,
        RUN,
        PULSE
    } state_e;

    typedef struct packed {
        logic            vld;
        logic [IdxW-1:0] idx;
    } pick_t;

    // Descending scan so the lowest qualifying bit is the one that sticks.
    function automatic pick_t next_masked(input logic [MaxDomains-1:0] mask,
                                          input logic [IdxW-1:0]       idx);
        pick_t r;
        r = '0;
        for (int i = MaxDomains - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                r.vld = 1'b1;
                r.idx = IdxW'(i);
            end
        end
        return r;
    endfunction

    // Callers guarantee a non-zero mask.
    function automatic logic [IdxW-1:0] first_masked(input logic [MaxDomains-1:0] mask);
        logic [IdxW-1:0] r;
        r = '0;
        for (int i = MaxDomains - 1; i >= 0; i--) begin
            if (mask[i]) r = IdxW'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter that holds at zero.
module rst_seq_cnt #(
    parameter int CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load,
    input  logic [CntWidth-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [CntWidth-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CntWidth'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: staggered per-domain release after global reset, plus
// software-requested pulse and re-release of a subset of domains.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NumDomains  = 4,
    parameter int CntWidth    = 8,
    parameter int PulseCycles = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumDomains-1:0][CntWidth-1:0] gap_i,
    input  logic                                req_i,
    input  logic [NumDomains-1:0]               req_mask_i,
    output logic                                ack_o,
    output logic                                busy_o,
    output logic [NumDomains-1:0]               rst_no
);

    localparam int IW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam logic [CntWidth-1:0] PulseLoad = CntWidth'(PulseCycles - 1);

    state_e                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [NumDomains-1:0] mask_q, mask_nxt;
    logic [NumDomains-1:0] rst_q, rst_nxt;
    logic                  first, first_nxt;
    logic                  busy;

    logic                  cnt_load, cnt_dec, cnt_zero;
    logic [CntWidth-1:0]   cnt_val;

    logic [MaxDomains-1:0] mask_ext;
    pick_t                 nxt_pick;
    logic [IdxW-1:0]       low_idx;

    assign mask_ext = MaxDomains'(mask_q);
    assign nxt_pick = next_masked(mask_ext, IdxW'(idx));
    assign low_idx  = first_masked(mask_ext);

    rst_seq_cnt #(.CntWidth(CntWidth)) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= SEQ;
            idx    <= '0;
            mask_q <= '1;
            rst_q  <= '0;
            first  <= 1'b1;
            busy   <= 1'b1;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            mask_q <= mask_nxt;
            rst_q  <= rst_nxt;
            first  <= first_nxt;
            busy   <= (state != RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mask_nxt  = mask_q;
        rst_nxt   = rst_q;
        first_nxt = first;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        unique case (state)
            SEQ: begin
                // The first post-reset cycle stands in for the load edge, so it
                // already counts as one gap cycle: load gap-1, or release at once.
                if (first && (gap_i[0] != '0)) begin
                    first_nxt = 1'b0;
                    cnt_load  = 1'b1;
                    cnt_val   = gap_i[0] - CntWidth'(1);
                end else if (!first && !cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    first_nxt    = 1'b0;
                    rst_nxt[idx] = 1'b1;
                    if (nxt_pick.vld) begin
                        idx_nxt  = IW'(nxt_pick.idx);
                        cnt_load = 1'b1;
                        cnt_val  = gap_i[IW'(nxt_pick.idx)];
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (req_i && (req_mask_i != '0)) begin
                    mask_nxt  = req_mask_i;
                    rst_nxt   = rst_q & ~req_mask_i;
                    cnt_load  = 1'b1;
                    cnt_val   = PulseLoad;
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_nxt = SEQ;
                    idx_nxt   = IW'(low_idx);
                    cnt_load  = 1'b1;
                    cnt_val   = gap_i[IW'(low_idx)];
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nxt = SEQ;
        endcase
    end

    assign ack_o  = (state == RUN) & req_i;
    assign busy_o = busy;
    assign rst_no = rst_q;

    if (NumDomains < 1 || NumDomains > MaxDomains) begin : g_bad_nd
        $fatal(1, "rst_seq_ctrl: NumDomains out of range");
    end
    if (PulseCycles < 1 || longint'(PulseCycles) > (64'd1 << CntWidth)) begin : g_bad_pc
        $fatal(1, "rst_seq_ctrl: PulseCycles out of range");
    end

    a_mask_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !ack_o) |=> $stable(req_mask_i))
        else $fatal(1, "rst_seq_ctrl: req_mask_i changed before ack");

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: power-up timing, soft reset, async reset, gap changes.
module tb_rst_seq_ctrl;

    localparam int ND = 4;
    localparam int CW = 8;
    localparam int PC = 4;

    logic                    clk = 1'b0;
    logic                    rst_ni;
    logic [ND-1:0][CW-1:0]   gap_i;
    logic                    req_i;
    logic [ND-1:0]           req_mask_i;
    logic                    ack_o;
    logic                    busy_o;
    logic [ND-1:0]           rst_no;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NumDomains  (ND),
        .CntWidth    (CW),
        .PulseCycles (PC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .gap_i      (gap_i),
        .req_i      (req_i),
        .req_mask_i (req_mask_i),
        .ack_o      (ack_o),
        .busy_o     (busy_o),
        .rst_no     (rst_no)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_gaps(input int g0, input int g1, input int g2, input int g3);
        gap_i[0] = CW'(g0);
        gap_i[1] = CW'(g1);
        gap_i[2] = CW'(g2);
        gap_i[3] = CW'(g3);
    endtask

    // Asserts reset now, checks the reset outputs, deasserts just after "edge 0".
    task automatic reset_dut();
        rst_ni = 1'b0;
        #1;
        chk("reset", 32'({ack_o, busy_o, rst_no}), 32'h10);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // Samples {ack, busy, rst_no} after edges 1..n against hand-computed release edges.
    task automatic run_seq(input string tag, input int r0, input int r1, input int r2,
                           input int r3, input int fall, input int ack_from,
                           input int drop_e, input int poke_e, input int n);
        int         rel[4];
        logic [3:0] er;
        logic       eb, ea;
        rel = '{r0, r1, r2, r3};
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) er[k] = (e >= rel[k]);
            eb = (e < fall);
            ea = (ack_from != 0) && (e >= ack_from) && ((drop_e == 0) || (e <= drop_e));
            chk($sformatf("%s e%0d", tag, e), 32'({ack_o, busy_o, rst_no}), 32'({ea, eb, er}));
            if (e == drop_e) req_i = 1'b0;
            if (e == poke_e) gap_i[2] = '0;
        end
    endtask

    initial begin
        logic [3:0] er;
        logic       eb;
        rst_ni     = 1'b1;
        req_i      = 1'b1;
        req_mask_i = '0;
        set_gaps(2, 0, 5, 1);
        #2;

        // Power-up with a zero-mask request held throughout: ack only once in RUN.
        reset_dut();
        run_seq("powerup", 3, 4, 10, 12, 13, 12, 13, 0, 14);

        // Soft reset of domains 0 and 2.
        req_mask_i = 4'b0101;
        req_i      = 1'b1;
        #1;
        chk("soft ack", 32'(ack_o), 32'h1);
        for (int p = 0; p <= 14; p++) begin
            @(posedge clk);
            #1;
            er = {1'b1, (p >= 13), 1'b1, (p >= 7)};
            eb = (p >= 1) && (p <= 13);
            chk($sformatf("soft p%0d", p), 32'({ack_o, busy_o, rst_no}), 32'({1'b0, eb, er}));
            if (p == 0) req_i = 1'b0;
        end

        // Async reset while pulsing; full sequence replays, with a gap poke mid-count.
        req_mask_i = 4'b0011;
        req_i      = 1'b1;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        chk("pulse start", 32'(rst_no), 32'hc);
        @(posedge clk);
        #3;
        reset_dut();
        run_seq("replay", 3, 4, 10, 12, 13, 0, 0, 6, 14);

        // All-zero gaps release one domain per edge.
        set_gaps(0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_dut();
        run_seq("zerogap", 1, 2, 3, 4, 5, 0, 0, 0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
